// File: rtl/case_sweep_pkg.sv
// Shared definitions for the case-decoder sweep controller: FSM encoding and a width helper.
package case_sweep_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        HOLD  = ST_HOLD,
        CHECK = ST_CHECK,
        DONE  = ST_DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/case_sweep_expect.sv
// Expected decoder output for a select code: two matched codes, first match wins, else default.
module case_sweep_expect
    import case_sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sel,
    input  logic [WIDTH-1:0] cfg_code0,
    input  logic [WIDTH-1:0] cfg_val0,
    input  logic [WIDTH-1:0] cfg_code1,
    input  logic [WIDTH-1:0] cfg_val1,
    input  logic [WIDTH-1:0] cfg_dflt,
    output logic [WIDTH-1:0] exp_val
);

    always_comb begin
        exp_val = cfg_dflt;
        if (sel == cfg_code0) begin
            exp_val = cfg_val0;
        end else if (sel == cfg_code1) begin
            exp_val = cfg_val1;
        end
    end

endmodule

// File: rtl/case_sweep_ctrl.sv
// Sweeps every select code through a decoder, holds each for SETTLE cycles, then checks dec_i.
// Optional build macro CASE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module case_sweep_ctrl
    import case_sweep_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_code0,
    input  logic [WIDTH-1:0] cfg_val0,
    input  logic [WIDTH-1:0] cfg_code1,
    input  logic [WIDTH-1:0] cfg_val1,
    input  logic [WIDTH-1:0] cfg_dflt,
    output logic [WIDTH-1:0] sel_o,
    input  logic [WIDTH-1:0] dec_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0] first_err_sel,
    output logic [WIDTH-1:0] first_err_val
);

    localparam int CW = clog2(SETTLE + 1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [WIDTH-1:0] exp_val;
    logic            mismatch;
    logic            last_code;

    case_sweep_expect #(.WIDTH(WIDTH)) u_expect (
        .sel       (sel_o),
        .cfg_code0 (cfg_code0),
        .cfg_val0  (cfg_val0),
        .cfg_code1 (cfg_code1),
        .cfg_val1  (cfg_val1),
        .cfg_dflt  (cfg_dflt),
        .exp_val   (exp_val)
    );

    // Strict compare so an undriven or unknown decoder output is flagged.
    assign mismatch  = (dec_i !== exp_val);
    assign last_code = (sel_o == {WIDTH{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            sel_o         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            first_err_sel <= '0;
            first_err_val <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= HOLD;
                        wait_cnt      <= '0;
                        sel_o         <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_sel <= '0;
                        first_err_val <= '0;
                    end
                end
                HOLD: begin
                    if (wait_cnt == CW'(SETTLE - 1)) begin
                        wait_cnt <= '0;
                        state    <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_err_sel <= sel_o;
                            first_err_val <= dec_i;
                        end
                    end
`ifdef CASE_SWEEP_STOP_ON_FAIL_EN
                    if (mismatch || last_code) begin
`else
                    if (last_code) begin
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sel_o <= sel_o + 1'b1;
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_case_sweep_ctrl.sv
// Bench for case_sweep_ctrl: table-driven decoder stand-in, sweep-level reference model.
module tb_case_sweep_ctrl;

    localparam int W = 8;
    localparam int S = 1;
    localparam int NCODE = 2 ** W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] cfg_code0, cfg_val0, cfg_code1, cfg_val1, cfg_dflt;
    logic [W-1:0] sel_o;
    logic [W-1:0] dec_i;
    logic         busy, done;
    logic [W:0]   err_cnt;
    logic [W-1:0] first_err_sel, first_err_val;

    logic [W-1:0] dec_tab [0:NCODE-1];
    logic [31:0]  exp_q [$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    case_sweep_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_code0     (cfg_code0),
        .cfg_val0      (cfg_val0),
        .cfg_code1     (cfg_code1),
        .cfg_val1      (cfg_val1),
        .cfg_dflt      (cfg_dflt),
        .sel_o         (sel_o),
        .dec_i         (dec_i),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .first_err_sel (first_err_sel),
        .first_err_val (first_err_val)
    );

    // Decoder stand-in: whatever the current test loaded into the table.
    always_comb dec_i = dec_tab[sel_o];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Intended decoder: default, overridden by code1, overridden again by code0.
    function automatic logic [W-1:0] ref_val(input int s);
        logic [W-1:0] v;
        v = cfg_dflt;
        if (s == int'(cfg_code1)) v = cfg_val1;
        if (s == int'(cfg_code0)) v = cfg_val0;
        return v;
    endfunction

    task automatic fill_correct();
        for (int s = 0; s < NCODE; s++) dec_tab[s] = ref_val(s);
    endtask

    task automatic set_cfg(input logic [W-1:0] c0, input logic [W-1:0] v0,
                           input logic [W-1:0] c1, input logic [W-1:0] v1,
                           input logic [W-1:0] df);
        cfg_code0 = c0; cfg_val0 = v0; cfg_code1 = c1; cfg_val1 = v1; cfg_dflt = df;
    endtask

    // Push expected sweep outcome: cycles, err_cnt, first sel, first val, final sel.
    task automatic predict();
        int n_err, stop_idx;
        logic [W-1:0] fsel, fval;
        n_err = 0; fsel = '0; fval = '0; stop_idx = NCODE - 1;
        for (int s = 0; s < NCODE; s++) begin
            if (dec_tab[s] !== ref_val(s)) begin
                if (n_err == 0) begin
                    fsel = W'(s);
                    fval = dec_tab[s];
                end
                n_err++;
`ifdef CASE_SWEEP_STOP_ON_FAIL_EN
                stop_idx = s;
                break;
`endif
            end
        end
        exp_q.push_back((stop_idx + 1) * (S + 1) + 1);
        exp_q.push_back(n_err);
        exp_q.push_back(32'(fsel));
        exp_q.push_back(32'(fval));
        exp_q.push_back(stop_idx);
    endtask

    task automatic run_sweep(input string tag, input bit poke);
        int cycles;
        logic [W-1:0] prev_sel;
        predict();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 1;
        check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
        check({tag, "_sel_start"}, 32'(sel_o), 32'd0);
        prev_sel = sel_o;
        while (!done && cycles < 4 * NCODE * (S + 1)) begin
            start = poke && ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
            cycles++;
            if (sel_o != prev_sel)
                check({tag, "_sel_step"}, {23'd0, 1'b0, sel_o}, {23'd0, {1'b0, prev_sel} + 9'd1});
            prev_sel = sel_o;
        end
        start = 1'b0;
        check({tag, "_cycles"}, cycles, exp_q.pop_front());
        check({tag, "_err_cnt"}, 32'(err_cnt), exp_q.pop_front());
        check({tag, "_first_sel"}, 32'(first_err_sel), exp_q.pop_front());
        check({tag, "_first_val"}, 32'(first_err_val), exp_q.pop_front());
        check({tag, "_final_sel"}, 32'(sel_o), exp_q.pop_front());
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_held"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, 32'(sel_o), 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_first_sel"}, 32'(first_err_sel), 32'd0);
        check({tag, "_first_val"}, 32'(first_err_val), 32'd0);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        start = 1'b0;
        set_cfg(8'h2a, 8'h40, 8'h1f, 8'h20, 8'h04);
        fill_correct();
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Correct decoder
        run_sweep("t1_clean", 1'b0);

        // Single wrong value at 1f
        fill_correct();
        dec_tab[8'h1f] = 8'h05;
        run_sweep("t2_fault1f", 1'b0);

        // Stuck at default
        for (int s = 0; s < NCODE; s++) dec_tab[s] = 8'h04;
        run_sweep("t3_stuck", 1'b0);

        // Equal codes: code0 wins
        set_cfg(8'h2a, 8'h40, 8'h2a, 8'h80, 8'h04);
        fill_correct();
        run_sweep("t4_equal", 1'b0);

        // Reset mid-sweep, then a fresh sweep from 00
        set_cfg(8'h2a, 8'h40, 8'h1f, 8'h20, 8'h04);
        fill_correct();
        dec_tab[8'h10] = 8'h11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (sel_o != 8'h80 && guard < 4 * NCODE) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("t5_reach80", 32'(sel_o), 32'h80);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("t5_midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        fill_correct();
        run_sweep("t5_after", 1'b0);

        // start pokes while busy must not disturb the sweep
        dec_tab[8'h33] = 8'h99;
        run_sweep("t6_poke", 1'b1);

        // Randomized configurations and sparse faults
        for (int t = 0; t < 6; t++) begin
            set_cfg(W'($urandom), W'($urandom),
                    ($urandom_range(0, 3) == 0) ? cfg_code0 : W'($urandom),
                    W'($urandom), W'($urandom));
            fill_correct();
            for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
                int idx;
                idx = $urandom_range(0, NCODE - 1);
                dec_tab[idx] = dec_tab[idx] ^ W'($urandom_range(1, NCODE - 1));
            end
            run_sweep($sformatf("rnd%0d", t), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
